multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the shared single-ALU / single-memory MIPS datapath over multiple cycles: fetch, decode, execute, memory, writeback.
- Consumes the IR opcode, the ALU zero flag and a memory ready handshake.
- Drives all datapath mux selects, write enables and the 2-bit alu_op_sig into the existing ALU control decoder.
- Supports R-type, LW, SW, BEQ and ORI; any other opcode is flagged illegal and retired as a NOP.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles to wait for mem_ready before flagging a bus timeout; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  6  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_wrt_sig  out  1  PC load enable
- pc_src_sig  out  1  0 = ALU result, 1 = ALU-out register (branch target)
- ir_wrt_sig  out  1  instruction register load
- iord_sig  out  1  memory address: 0 = PC, 1 = ALU-out
- mem_read_sig  out  1  memory read strobe
- mem_wrt_sig  out  1  memory write strobe
- reg_wrt_sig  out  1  register file write enable
- reg_dst_sig  out  1  write address: 1 = rd, 0 = rt
- mem_reg_sig  out  1  writeback data: 1 = memory, 0 = ALU-out
- alu_src_a_sig  out  1  0 = PC, 1 = rs register
- alu_src_b_sig  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2
- alu_op_sig  out  2  00 add, 01 subtract, 10 R-type funct, 11 OR
- illegal_sig  out  1  one-cycle pulse on an unknown opcode
- timeout_sig  out  1  one-cycle pulse on a memory wait timeout
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - While rst is high: state <= FETCH, wait counter <= 0, and every control output reads 0 (outputs are gated by rst).
  - Reset mid-instruction aborts it; no write strobe is asserted in the reset cycle.
- FETCH (0):
  - Asserts mem_read_sig=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_wrt_sig and pc_wrt_sig equal mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE (1):
  - Asserts alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALU-out).
  - op is sampled only in this state.
  - Next state: 000000 -> EXEC_R; 100011 or 101011 -> ADDR; 000100 -> BRANCH; 001101 -> EXEC_ORI.
  - Any other opcode: illegal_sig=1 this cycle, next state FETCH.
- ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD for LW, MEM_WR for SW, using the op latched in DECODE.
- MEM_RD (3): mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB (4): reg_wrt=1, mem_reg=1, reg_dst=0, then FETCH.
- MEM_WR (5): mem_wrt=1, iord=1. Holds until mem_ready, then FETCH.
- EXEC_R (6): alu_src_a=1, alu_src_b=00, alu_op=10, then ALU_WB with internal dst_flag=1.
- EXEC_ORI (7): alu_src_a=1, alu_src_b=10, alu_op=11, then ALU_WB with dst_flag=0.
- ALU_WB (8): reg_wrt=1, mem_reg=0, reg_dst=dst_flag, then FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_wrt=zero, then FETCH.
- Latency with zero wait states:
  - BEQ 3 cycles; SW 4; R-type 4; ORI 4; LW 5; illegal 2.
  - Each wait cycle adds 1.
- Memory waits:
  - Wait counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments on each cycle without mem_ready.
  - Timeout occurs when MEM_WAIT_MAX≠0 and the counter reaches MEM_WAIT_MAX. Response: timeout_sig pulse, strobes drop, next state FETCH, PC not written.
  - mem_ready and timeout on the same cycle: mem_ready wins.
- Unused state encodings (10-15) recover to FETCH on the next clock with all outputs 0.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt[31:0]: counts every non-reset cycle.
  - inst_cnt[31:0]: increments on each transition into FETCH from a non-FETCH state (retired instructions, illegal ones included).
- Both counters clear on rst and wrap modulo 2^32.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared include header ctrl_defs.vh holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI);
  - alu_op encodings;
  - alu_src_b select encodings.
- One sub-module, mem_wait_timer: the wait counter plus timeout compare, parameterised by MEM_WAIT_MAX.

Test Plan:
- rst held 3 cycles, then released with mem_ready=1 -> all outputs 0 during reset; first post-reset cycle state=0 with mem_read=1, ir_wrt=1, pc_wrt=1.
- LW (op=100011), mem_ready held 0 for 2 cycles in MEM_RD -> state sequence 0,1,2,3,3,3,4,0; reg_wrt=1 and mem_reg=1 only in state 4.
- BEQ, once with zero=1 and once with zero=0 -> pc_wrt=1 with pc_src=1 in state 9 only when zero=1; returns to state 0 after 3 cycles.
- ORI followed by R-type -> reg_dst=0 in the first ALU_WB and 1 in the second; alu_op=11 then 10.
- op=111111 -> illegal_sig pulses in DECODE, state 1→0, no write strobe asserted.
- MEM_WAIT_MAX=4, SW with mem_ready never asserted -> mem_wrt high 4 cycles, timeout_sig pulse, state returns to 0; with CTRL_PERF_CNT_EN, inst_cnt increments by 1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcodes, ALU operation and ALU B-source select codes, control bundle.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      ADDR     = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_ORI = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // Datapath control bundle produced by the state decoder each cycle.
   typedef struct packed {
      logic       pc_wrt;
      logic       pc_src;
      logic       ir_wrt;
      logic       iord;
      logic       mem_read;
      logic       mem_wrt;
      logic       reg_wrt;
      logic       reg_dst;
      logic       mem_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. The controller side is "master".
// CTRL_PERF_CNT_EN adds the cycle_cnt / inst_cnt performance counters.
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_wrt_sig;
   logic       pc_src_sig;
   logic       ir_wrt_sig;
   logic       iord_sig;
   logic       mem_read_sig;
   logic       mem_wrt_sig;
   logic       reg_wrt_sig;
   logic       reg_dst_sig;
   logic       mem_reg_sig;
   logic       alu_src_a_sig;
   logic [1:0] alu_src_b_sig;
   logic [1:0] alu_op_sig;
   logic       illegal_sig;
   logic       timeout_sig;
   logic [3:0] state;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] inst_cnt;
`endif

   modport master (
      input  op, zero, mem_ready,
      output pc_wrt_sig, pc_src_sig, ir_wrt_sig, iord_sig, mem_read_sig,
             mem_wrt_sig, reg_wrt_sig, reg_dst_sig, mem_reg_sig,
             alu_src_a_sig, alu_src_b_sig, alu_op_sig, illegal_sig,
             timeout_sig, state
`ifdef CTRL_PERF_CNT_EN
      , output cycle_cnt, inst_cnt
`endif
   );

   modport slave (
      output op, zero, mem_ready,
      input  pc_wrt_sig, pc_src_sig, ir_wrt_sig, iord_sig, mem_read_sig,
             mem_wrt_sig, reg_wrt_sig, reg_dst_sig, mem_reg_sig,
             alu_src_a_sig, alu_src_b_sig, alu_op_sig, illegal_sig,
             timeout_sig, state
`ifdef CTRL_PERF_CNT_EN
      , input cycle_cnt, inst_cnt
`endif
   );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter with timeout compare. MEM_WAIT_MAX = 0 disables the
// timeout. The counter saturates at MEM_WAIT_MAX so it never wraps.
module mem_wait_timer #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,        // entering (or re-entering) a wait state
   input  logic wait_i,       // current state waits on mem_ready
   input  logic mem_ready_i,
   output logic timeout_o
);
   localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count cycles spent without mem_ready, cleared on every state entry.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (wait_i && !mem_ready_i && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CW'(1);
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // mem_ready takes priority over a timeout landing on the same cycle.
   assign timeout_o = (MEM_WAIT_MAX != 0) && wait_i && !mem_ready_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle MIPS datapath (R-type, LW, SW, BEQ,
// ORI). Optional macro CTRL_PERF_CNT_EN adds cycle / retired-instruction
// counters. All control outputs are forced low while rst is high.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input logic               clk,
   input logic               rst,
   multicycle_ctrl_if.master bus
);
   state_e state_q, state_d;
   logic   lw_q, lw_d;     // instruction in flight is a load (vs store)
   logic   dst_q, dst_d;   // ALU writeback targets rd (1) or rt (0)
   ctrl_t  ctl, ctl_g;
   logic   illegal_c;
   logic   wait_c, tmr_clr, tmo;

   assign wait_c  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   assign tmr_clr = tmo || (state_d != state_q);

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (tmr_clr),
      .wait_i     (wait_c),
      .mem_ready_i(bus.mem_ready),
      .timeout_o  (tmo)
   );

   // Next-state and control decode; a timeout drops the strobes and refetches.
   always_comb begin
      ctl       = '0;
      state_d   = state_q;
      lw_d      = lw_q;
      dst_d     = dst_q;
      illegal_c = 1'b0;
      case (state_q)
         FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            if (bus.mem_ready) begin
               ctl.ir_wrt = 1'b1;
               ctl.pc_wrt = 1'b1;
               state_d    = DECODE;
            end else if (tmo) begin
               ctl.mem_read = 1'b0;
            end
         end
         DECODE: begin
            ctl.alu_src_b = SRCB_IMM_SH;
            lw_d = (bus.op == OP_LW);
            case (bus.op)
               OP_RTYPE:     state_d = EXEC_R;
               OP_LW, OP_SW: state_d = ADDR;
               OP_BEQ:       state_d = BRANCH;
               OP_ORI:       state_d = EXEC_ORI;
               default: begin
                  illegal_c = 1'b1;
                  state_d   = FETCH;
               end
            endcase
         end
         ADDR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            state_d = lw_q ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            if (bus.mem_ready) begin
               state_d = MEM_WB;
            end else if (tmo) begin
               ctl.mem_read = 1'b0;
               state_d      = FETCH;
            end
         end
         MEM_WB: begin
            ctl.reg_wrt = 1'b1;
            ctl.mem_reg = 1'b1;
            state_d     = FETCH;
         end
         MEM_WR: begin
            ctl.mem_wrt = 1'b1;
            ctl.iord    = 1'b1;
            if (bus.mem_ready) begin
               state_d = FETCH;
            end else if (tmo) begin
               ctl.mem_wrt = 1'b0;
               state_d     = FETCH;
            end
         end
         EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_RT;
            ctl.alu_op    = ALU_FUNCT;
            dst_d         = 1'b1;
            state_d       = ALU_WB;
         end
         EXEC_ORI: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            ctl.alu_op    = ALU_OR;
            dst_d         = 1'b0;
            state_d       = ALU_WB;
         end
         ALU_WB: begin
            ctl.reg_wrt = 1'b1;
            ctl.reg_dst = dst_q;
            state_d     = FETCH;
         end
         BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_RT;
            ctl.alu_op    = ALU_SUB;
            ctl.pc_src    = 1'b1;
            ctl.pc_wrt    = bus.zero;
            state_d       = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // State and per-instruction flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         lw_q    <= 1'b0;
         dst_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lw_q    <= lw_d;
         dst_q   <= dst_d;
      end
   end

   assign ctl_g = rst ? '0 : ctl;

   assign bus.pc_wrt_sig    = ctl_g.pc_wrt;
   assign bus.pc_src_sig    = ctl_g.pc_src;
   assign bus.ir_wrt_sig    = ctl_g.ir_wrt;
   assign bus.iord_sig      = ctl_g.iord;
   assign bus.mem_read_sig  = ctl_g.mem_read;
   assign bus.mem_wrt_sig   = ctl_g.mem_wrt;
   assign bus.reg_wrt_sig   = ctl_g.reg_wrt;
   assign bus.reg_dst_sig   = ctl_g.reg_dst;
   assign bus.mem_reg_sig   = ctl_g.mem_reg;
   assign bus.alu_src_a_sig = ctl_g.alu_src_a;
   assign bus.alu_src_b_sig = ctl_g.alu_src_b;
   assign bus.alu_op_sig    = ctl_g.alu_op;
   assign bus.illegal_sig   = !rst && illegal_c;
   assign bus.timeout_sig   = !rst && tmo;
   assign bus.state         = rst ? 4'd0 : state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, inst_cnt_q;

   // Free-running cycle count and retired-instruction count (return to FETCH).
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         inst_cnt_q  <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if ((state_d == FETCH) && (state_q != FETCH))
            inst_cnt_q <= inst_cnt_q + 32'd1;
      end
   end

   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.inst_cnt  = inst_cnt_q;
`endif

endmodule
